// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz timing constants shared by the display pipeline.
// Drawing stages import this for H_DISPLAY/V_DISPLAY and the coordinate type.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_DISPLAY = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;

    localparam int V_DISPLAY = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_DISPLAY + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: scan position and sync bundle from the timing generator.
// f_tick exists only when VGA_FRAME_TICK_EN is defined.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   p_tick;
    coord_t x;
    coord_t y;
`ifdef VGA_FRAME_TICK_EN
    logic   f_tick;

    modport master (
        output hsync, vsync, video_on, p_tick, x, y, f_tick
    );
    modport slave (
        input hsync, vsync, video_on, p_tick, x, y, f_tick
    );
`else
    modport master (
        output hsync, vsync, video_on, p_tick, x, y
    );
    modport slave (
        input hsync, vsync, video_on, p_tick, x, y
    );
`endif

endinterface

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// pixel_tick_gen: divides clk by CLK_DIV into a one-clk pixel enable.
// With CLK_DIV == 1 there is no divider and the enable is tied high.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic p_tick
);

    generate
        if (CLK_DIV > 1) begin : g_div
            localparam int DW = $clog2(CLK_DIV);
            localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
            localparam logic [DW-1:0] ONE  = DW'(1);

            logic [DW-1:0] div_cnt;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    div_cnt <= '0;
                end else if (div_cnt == LAST) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + ONE;
                end
            end

            assign p_tick = (div_cnt == LAST);
        end else begin : g_nodiv
            assign p_tick = 1'b1;
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA scan counters, hsync/vsync and blanking for the pipeline.
// Optional end-of-frame strobe f_tick under VGA_FRAME_TICK_EN.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FP      = vga_timing_pkg::H_FP,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BP      = vga_timing_pkg::H_BP,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FP      = vga_timing_pkg::V_FP,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BP      = vga_timing_pkg::V_BP
) (
    input  logic                  clk,
    input  logic                  reset_n,
    vga_sync_gen_if.master        bus
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS  = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS  = coord_t'(V_DISPLAY);
    localparam coord_t HS_LO  = coord_t'(H_DISPLAY + H_FP);
    localparam coord_t HS_HI  = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam coord_t VS_LO  = coord_t'(V_DISPLAY + V_FP);
    localparam coord_t VS_HI  = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);
    localparam coord_t ONE    = coord_t'(1);

    logic   p_tick;
    logic   hsync;
    logic   vsync;
    coord_t x;
    coord_t y;
    coord_t next_x;
    coord_t next_y;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .p_tick  (p_tick)
    );

    always_comb begin
        next_x = x + ONE;
        next_y = y;
        if (x == H_LAST) begin
            next_x = '0;
            next_y = (y == V_LAST) ? '0 : y + ONE;
        end
    end

    // Syncs decode next_x/next_y so they change on the same edge as x/y.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x     <= '0;
            y     <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (p_tick) begin
            x     <= next_x;
            y     <= next_y;
            hsync <= !((next_x >= HS_LO) && (next_x <= HS_HI));
            vsync <= !((next_y >= VS_LO) && (next_y <= VS_HI));
        end
    end

    assign bus.x        = x;
    assign bus.y        = y;
    assign bus.hsync    = hsync;
    assign bus.vsync    = vsync;
    assign bus.p_tick   = p_tick;
    assign bus.video_on = (x < H_VIS) && (y < V_VIS);

`ifdef VGA_FRAME_TICK_EN
    assign bus.f_tick = reset_n && p_tick && (x == H_LAST) && (y == V_LAST);
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: vector table + scoreboard bench for vga_sync_gen.
// dut_a uses full 640x480 timing; dut_b a shrunken frame for vsync/wrap cases.
`timescale 1ns/1ps
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    vga_sync_gen_if bus_a();
    vga_sync_gen_if bus_b();

    vga_sync_gen #(.CLK_DIV(4)) dut_a (
        .clk     (clk),
        .reset_n (rst_a),
        .bus     (bus_a)
    );

    vga_sync_gen #(
        .CLK_DIV(2),
        .H_DISPLAY(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_DISPLAY(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_b (
        .clk     (clk),
        .reset_n (rst_b),
        .bus     (bus_b)
    );

    typedef struct {
        int   sel;
        int   fr;
        int   px;
        int   py;
        int   off;
        logic pt;
        logic hs;
        logic vs;
        logic von;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];
    vec_t exp_q[$];

    int ca = 0;
    int cb = 0;
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(int sel, int fr, int px, int py, int off,
                                logic pt, logic hs, logic vs, logic von);
        vec_t v;
        v.sel = sel; v.fr = fr; v.px = px; v.py = py; v.off = off;
        v.pt = pt; v.hs = hs; v.vs = vs; v.von = von;
        return v;
    endfunction

    // Clocks since release implied by a (frame, x, y, divider phase) point.
    function automatic int target(vec_t v);
        if (v.sel == 0) return ((v.fr * 525 + v.py) * 800 + v.px) * 4 + v.off;
        return ((v.fr * 19 + v.py) * 25 + v.px) * 2 + v.off;
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_a) ca = 0; else ca++;
        if (!rst_b) cb = 0; else cb++;
        #1;
    endtask

    task automatic run_to(int sel, int t);
        int guard = 0;
        while (((sel == 0) ? ca : cb) < t && guard < 50000) begin
            step();
            guard++;
        end
        if (((sel == 0) ? ca : cb) != t) begin
            checks++;
            errors++;
            $display("FAIL run_to: at clk %0d, required %0d",
                     (sel == 0) ? ca : cb, t);
        end
    endtask

    task automatic compare_pop();
        vec_t   v;
        coord_t ax, ay;
        logic   apt, ahs, avs, avon;
        v = exp_q.pop_front();
        if (v.sel == 0) begin
            ax = bus_a.x; ay = bus_a.y; apt = bus_a.p_tick;
            ahs = bus_a.hsync; avs = bus_a.vsync; avon = bus_a.video_on;
        end else begin
            ax = bus_b.x; ay = bus_b.y; apt = bus_b.p_tick;
            ahs = bus_b.hsync; avs = bus_b.vsync; avon = bus_b.video_on;
        end
        checks++;
        if (ax !== coord_t'(v.px) || ay !== coord_t'(v.py) || apt !== v.pt ||
            ahs !== v.hs || avs !== v.vs || avon !== v.von) begin
            errors++;
            $display("FAIL vec dut%0d (%0d,%0d,+%0d): got x=%0d y=%0d pt=%b hs=%b vs=%b von=%b, want pt=%b hs=%b vs=%b von=%b",
                     v.sel, v.px, v.py, v.off, ax, ay, apt, ahs, avs, avon,
                     v.pt, v.hs, v.vs, v.von);
        end
    endtask

    task automatic apply(vec_t v);
        run_to(v.sel, target(v));
        exp_q.push_back(v);
        compare_pop();
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        int hs_low;
        int vs_low;
        int ticks;
        int ft_cnt;
        int ft_x;
        int ft_y;

        //                 sel fr  x    y  off pt  hs  vs  von
        vecs_a.push_back(mk(0, 0,   0,  0, 0, 0, 1, 1, 1));
        vecs_a.push_back(mk(0, 0,   0,  0, 1, 0, 1, 1, 1));
        vecs_a.push_back(mk(0, 0,   0,  0, 3, 1, 1, 1, 1));
        vecs_a.push_back(mk(0, 0,   1,  0, 0, 0, 1, 1, 1));
        vecs_a.push_back(mk(0, 0,   1,  0, 3, 1, 1, 1, 1));
        vecs_a.push_back(mk(0, 0, 639,  0, 2, 0, 1, 1, 1));
        vecs_a.push_back(mk(0, 0, 640,  0, 0, 0, 1, 1, 0));
        vecs_a.push_back(mk(0, 0, 655,  0, 3, 1, 1, 1, 0));
        vecs_a.push_back(mk(0, 0, 656,  0, 0, 0, 0, 1, 0));
        vecs_a.push_back(mk(0, 0, 751,  0, 3, 1, 0, 1, 0));
        vecs_a.push_back(mk(0, 0, 752,  0, 0, 0, 1, 1, 0));
        vecs_a.push_back(mk(0, 0, 799,  0, 3, 1, 1, 1, 0));
        vecs_a.push_back(mk(0, 0,   0,  1, 0, 0, 1, 1, 1));

        vecs_b.push_back(mk(1, 0,  0,  0, 0, 0, 1, 1, 1));
        vecs_b.push_back(mk(1, 0, 15,  0, 1, 1, 1, 1, 1));
        vecs_b.push_back(mk(1, 0, 16,  0, 0, 0, 1, 1, 0));
        vecs_b.push_back(mk(1, 0, 24,  0, 1, 1, 1, 1, 0));
        vecs_b.push_back(mk(1, 0,  0,  1, 0, 0, 1, 1, 1));
        vecs_b.push_back(mk(1, 0, 18,  1, 0, 0, 0, 1, 0));
        vecs_b.push_back(mk(1, 0, 22,  1, 0, 0, 1, 1, 0));
        vecs_b.push_back(mk(1, 0, 15, 11, 0, 0, 1, 1, 1));
        vecs_b.push_back(mk(1, 0,  0, 12, 0, 0, 1, 1, 0));
        vecs_b.push_back(mk(1, 0, 24, 13, 1, 1, 1, 1, 0));
        vecs_b.push_back(mk(1, 0,  0, 14, 0, 0, 1, 0, 0));
        vecs_b.push_back(mk(1, 0, 24, 15, 1, 1, 1, 0, 0));
        vecs_b.push_back(mk(1, 0,  0, 16, 0, 0, 1, 1, 0));
        vecs_b.push_back(mk(1, 0, 24, 18, 1, 1, 1, 1, 0));
        vecs_b.push_back(mk(1, 1,  0,  0, 0, 0, 1, 1, 1));

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) step();
        rst_a = 1'b1;

        foreach (vecs_a[i]) apply(vecs_a[i]);

        // Line 1: hsync low for 96 pixels, 800 pixel ticks, y steps to 2.
        hs_low = 0;
        ticks  = 0;
        repeat (3200) begin
            step();
            if (!bus_a.hsync) hs_low++;
            if (bus_a.p_tick) ticks++;
        end
        check_int("hsync_low_clks", hs_low, 96 * 4);
        check_int("line_ticks", ticks, 800);
        apply(mk(0, 0, 0, 2, 0, 0, 1, 1, 1));

        // One-clk reset mid-divide while hsync is low.
        apply(mk(0, 0, 700, 2, 1, 0, 0, 1, 0));
        rst_a = 1'b0;
        step();
        apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 1));
        rst_a = 1'b1;
        apply(mk(0, 0, 0, 0, 2, 0, 1, 1, 1));
        apply(mk(0, 0, 0, 0, 3, 1, 1, 1, 1));
        apply(mk(0, 0, 1, 0, 0, 0, 1, 1, 1));

        rst_b = 1'b1;
        foreach (vecs_b[i]) apply(vecs_b[i]);

        // Full small frame: vsync low 2 lines, wrap back to origin.
        vs_low = 0;
        ticks  = 0;
        ft_cnt = 0;
        ft_x   = -1;
        ft_y   = -1;
        repeat (950) begin
            step();
            if (!bus_b.vsync) vs_low++;
            if (bus_b.p_tick) ticks++;
`ifdef VGA_FRAME_TICK_EN
            if (bus_b.f_tick) begin
                ft_cnt++;
                ft_x = int'(bus_b.x);
                ft_y = int'(bus_b.y);
            end
`endif
        end
        check_int("vsync_low_clks", vs_low, 2 * 25 * 2);
        check_int("frame_ticks", ticks, 475);
`ifdef VGA_FRAME_TICK_EN
        check_int("f_tick_count", ft_cnt, 1);
        check_int("f_tick_x", ft_x, 24);
        check_int("f_tick_y", ft_y, 18);
`endif
        apply(mk(1, 2, 0, 0, 0, 0, 1, 1, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA 640x480@60 Hz timing and produces the pixel coordinates x, y consumed by the text, graphics and colour-mux stages.
- Divides the 100 MHz system clock into a pixel-rate enable and runs the horizontal and vertical scan counters.
- Drives the hsync/vsync pins and the video_on blanking flag.
- Single source of screen-position truth for the whole display pipeline.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); legal range >= 1.
- H_DISPLAY, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync pulse width in lines.
- V_BP, 33, vertical back porch in lines.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset_n  input  1  synchronous reset, active-low.
- hsync  output  1  horizontal sync, active-low.
- vsync  output  1  vertical sync, active-low.
- video_on  output  1  high while (x, y) is inside the visible area.
- p_tick  output  1  one-clk pixel enable, once every CLK_DIV clks.
- x  output  10  current pixel column, 0..H_TOTAL-1.
- y  output  10  current line, 0..V_TOTAL-1.
- f_tick  output  1  end-of-frame pulse; port exists only under VGA_FRAME_TICK_EN.

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP = 525.
- One clock, reset_n. Reset is sampled only on the rising edge of clk. On reset_n=0 at an edge:
  - div_cnt=0, x=0, y=0, hsync=1, vsync=1.
  - Resulting outputs: p_tick=0 (when CLK_DIV>1), video_on=1.
- Reset mid-frame aborts the frame with no drain; the first edge after release resumes counting from div_cnt=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt == CLK_DIV-1), decoded combinationally from the register.
  - With CLK_DIV=1, p_tick is constantly 1.
- Horizontal counter: advances only on an edge where p_tick=1. At H_TOTAL-1 it wraps to 0.
- Vertical counter: advances only on an edge where p_tick=1 and x==H_TOTAL-1. At V_TOTAL-1 it wraps to 0, so the frame wraps at (799,524) -> (0,0).
- hsync register:
  - Loaded on p_tick edges from the next-x value.
  - Low iff next_x is in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1] = [656,751].
  - hsync is therefore aligned with the x it accompanies; no extra latency.
- vsync register: loaded the same way from next_y; low iff next_y is in [490,491].
- video_on = (x < H_DISPLAY) && (y < V_DISPLAY), combinational from the registers, so it has zero latency relative to x, y.
- x and y hold steady for CLK_DIV clks. Downstream logic samples on p_tick.
- x and y are 10-bit unsigned counters and never exceed H_TOTAL-1 / V_TOTAL-1.
- No other inputs; there are no simultaneous-event cases beyond reset, which has priority over counting.

Optional Feature:
- VGA_FRAME_TICK_EN defined:
  - Adds output f_tick.
  - f_tick = p_tick && x==H_TOTAL-1 && y==V_TOTAL-1, i.e. one clk per frame, coincident with the last pixel's tick.
  - It drives the game-logic update (ball/paddle step once per frame).
  - Forced 0 during reset.
- Undefined: no f_tick port, no logic; the game logic derives its own frame strobe.

Decomposition:
- Package vga_timing_pkg holds:
  - all timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL);
  - sync-window start/end constants;
  - the 10-bit coordinate width constant.
- Pong drawing modules import the package for H_DISPLAY/V_DISPLAY.
- One sub-module: pixel_tick_gen, holding the div_cnt register and p_tick decode, parameterised by CLK_DIV.

Test Plan:
- Reset release, CLK_DIV=4 -> p_tick first high on the 4th clk after release, then every 4 clks; x goes 0->1 at the edge after the first p_tick; video_on=1 throughout.
- Run one line -> hsync falls when x becomes 656 and rises when x becomes 752 (96 p_ticks low); x 799->0 and y 0->1 on the same edge.
- Run to y=489, x=799 -> vsync goes low as y becomes 490 and high as y becomes 492 (1600 p_ticks low); frame wraps (799,524) -> (0,0) with vsync=1.
- Blanking -> video_on=1 at (639,0) and (639,479); video_on=0 at (640,0), (0,480) and (799,524).
- Assert reset_n=0 for one clk at (300,200) mid-divide -> next edge gives x=0, y=0, hsync=vsync=1, div_cnt=0; p_tick next high 4 clks after release.
- VGA_FRAME_TICK_EN defined -> f_tick high exactly one clk per 420000 p_ticks, at (799,524); undefined build elaborates with no f_tick port.
